// File: rtl/lw_sha_feeder.sv
// rtl/lw_sha_feeder.sv - FIPS 180-4 message padder that streams 32-bit words into the SHA-256/224 core
module lw_sha_feeder (
  input  logic        clk_i,
  input  logic        aresetn_i,
  input  logic        hash_start_i,
  input  logic        hash_opcode_i,
  input  logic        hash_empty_i,
  input  logic        abort_i,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  input  logic [31:0] msg_data_i,
  input  logic        msg_last_i,
  input  logic [1:0]  msg_bytes_i,
  output logic        core_start_o,
  output logic        core_valid_o,
  output logic [31:0] core_data_o,
  output logic        core_last_o,
  output logic        core_opcode_o,
  output logic        core_abort_o,
  input  logic        core_ready_i,
  input  logic        core_idle_i,
  input  logic        core_done_i,
  output logic        busy_o
);

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MSG,
    S_PAD,
    S_ZERO,
    S_LEN_HI,
    S_LEN_LO,
    S_WAIT_DONE
  } state_t;

  state_t      state;
  state_t      after_marker;
  logic [63:0] len;
  logic [3:0]  widx;
  logic [3:0]  load_idx;
  logic        first_pending;
  logic        core_active;
  logic        consume;
  logic        out_free;
  logic        msg_take;
  logic [31:0] tail_word;

  // The core may show ready while still idle; the first word only counts once it has launched.
  assign consume      = core_valid_o && core_ready_i && (core_active || !first_pending);
  assign out_free     = !core_valid_o || consume;
  assign load_idx     = widx + {3'd0, core_valid_o};
  assign after_marker = (load_idx == 4'd13) ? S_LEN_HI : S_ZERO;
  assign msg_ready_o  = (state == S_MSG) && out_free && !abort_i;
  assign msg_take     = msg_ready_o && msg_valid_i;
  assign core_start_o = core_valid_o && first_pending;

  always_comb begin
    tail_word = msg_data_i;
    case (msg_bytes_i)
      2'd1:    tail_word = {msg_data_i[31:24], 8'h80, 16'h0000};
      2'd2:    tail_word = {msg_data_i[31:16], 8'h80, 8'h00};
      2'd3:    tail_word = {msg_data_i[31:8], 8'h80};
      default: tail_word = msg_data_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state         <= S_IDLE;
      len           <= '0;
      widx          <= '0;
      first_pending <= 1'b0;
      core_active   <= 1'b0;
      core_valid_o  <= 1'b0;
      core_data_o   <= '0;
      core_last_o   <= 1'b0;
      core_opcode_o <= 1'b0;
      core_abort_o  <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      core_abort_o <= abort_i;
      if (abort_i) begin
        state         <= S_IDLE;
        core_valid_o  <= 1'b0;
        core_data_o   <= '0;
        core_last_o   <= 1'b0;
        first_pending <= 1'b0;
        core_active   <= 1'b0;
        busy_o        <= 1'b0;
      end else begin
        if (core_start_o && core_idle_i) core_active <= 1'b1;
        if (consume) begin
          widx          <= widx + 4'd1;
          first_pending <= 1'b0;
          core_valid_o  <= 1'b0;
          core_last_o   <= 1'b0;
        end
        case (state)
          S_IDLE: begin
            if (hash_start_i) begin
              len           <= '0;
              widx          <= '0;
              core_opcode_o <= hash_opcode_i;
              busy_o        <= 1'b1;
              first_pending <= 1'b1;
              core_active   <= 1'b0;
              if (hash_empty_i) begin
                core_valid_o <= 1'b1;
                core_data_o  <= PAD_WORD;
                state        <= S_ZERO;
              end else begin
                state <= S_MSG;
              end
            end
          end
          S_MSG: begin
            if (msg_take) begin
              core_valid_o <= 1'b1;
              core_last_o  <= 1'b0;
              if (!msg_last_i) begin
                core_data_o <= msg_data_i;
                len         <= len + 64'd32;
              end else if (msg_bytes_i == 2'd0) begin
                core_data_o <= msg_data_i;
                len         <= len + 64'd32;
                state       <= S_PAD;
              end else begin
                core_data_o <= tail_word;
                len         <= len + {59'd0, msg_bytes_i, 3'd0};
                state       <= after_marker;
              end
            end
          end
          S_PAD: begin
            if (out_free) begin
              core_valid_o <= 1'b1;
              core_data_o  <= PAD_WORD;
              state        <= after_marker;
            end
          end
          // Zeros run through a block wrap when the marker left no room for the length.
          S_ZERO: begin
            if (out_free) begin
              core_valid_o <= 1'b1;
              core_data_o  <= '0;
              if (load_idx == 4'd13) state <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (out_free) begin
              core_valid_o <= 1'b1;
              core_data_o  <= len[63:32];
              state        <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (out_free && !core_last_o) begin
              core_valid_o <= 1'b1;
              core_data_o  <= len[31:0];
              core_last_o  <= 1'b1;
            end else if (consume) begin
              state <= S_WAIT_DONE;
            end
          end
          S_WAIT_DONE: begin
            if (core_done_i) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
